// File: rtl/tbuf_bus_pkg.sv
// Shared types and width helpers for the tri-state bus controller.
package tbuf_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_e;

  function automatic int src_w(input int n_drv);
    return (n_drv > 1) ? $clog2(n_drv) : 1;
  endfunction

  // Counter must hold both the settle preload and the dead-time preload.
  function automatic int cnt_w(input int settle, input int dead);
    int m;
    m = (settle > dead) ? settle : dead;
    return (m > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/tbuf_bus_ctrl_if.sv
// Request/enable/capture signals between the bus controller and its drivers.
interface tbuf_bus_ctrl_if #(
  parameter int N_DRV = 4,
  parameter int W     = 8
);
  localparam int SRC_W = tbuf_bus_pkg::src_w(N_DRV);

  logic [N_DRV-1:0] req;
  logic [W-1:0]     bus_in;
  logic [N_DRV-1:0] en;
  logic [N_DRV-1:0] en_bar;
  logic [N_DRV-1:0] gnt;
  logic [W-1:0]     rx_data;
  logic [SRC_W-1:0] rx_src;
  logic             rx_valid;
  logic             busy;

  modport master (
    input  req, bus_in,
    output en, en_bar, gnt, rx_data, rx_src, rx_valid, busy
  );

  modport slave (
    output req, bus_in,
    input  en, en_bar, gnt, rx_data, rx_src, rx_valid, busy
  );
endinterface

// File: rtl/tbuf_bus_rr_arb.sv
// Combinational round-robin arbiter: search starts just after the last winner.
module tbuf_bus_rr_arb #(
  parameter int N_DRV = 4,
  parameter int SRC_W = 2
) (
  input  logic [N_DRV-1:0] i_req,
  input  logic [SRC_W-1:0] i_last,
  output logic [N_DRV-1:0] o_gnt,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_any
);

  // Walk candidates farthest-first so the nearest requester overwrites the pick.
  always_comb begin
    int   cand;
    int   sel;
    logic hit;
    sel   = 0;
    o_any = 1'b0;
    for (int k = N_DRV; k >= 1; k--) begin
      cand  = (int'(i_last) + k) % N_DRV;
      hit   = i_req[cand];
      sel   = hit ? cand : sel;
      o_any = o_any | hit;
    end
    o_gnt      = '0;
    o_gnt[sel] = o_any;
    o_idx      = SRC_W'(sel);
  end

endmodule

// File: rtl/tbuf_bus_ctrl.sv
// Tri-state bus owner sequencer: round-robin grant, settle wait, capture, dead time.
module tbuf_bus_ctrl
  import tbuf_bus_pkg::*;
#(
  parameter int N_DRV  = 4,
  parameter int W      = 8,
  parameter int SETTLE = 1,
  parameter int DEAD   = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  tbuf_bus_ctrl_if.master bus
);

  localparam int SRC_W = src_w(N_DRV);
  localparam int CNT_W = cnt_w(SETTLE, DEAD);
  localparam logic [CNT_W-1:0] C_SETTLE  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] C_DEAD_M1 = CNT_W'(DEAD - 1);

  generate
    if (DEAD < 1) begin : g_bad_dead
      $error("tbuf_bus_ctrl: DEAD must be at least 1");
    end
  endgenerate

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SRC_W-1:0] r_last;
  logic [SRC_W-1:0] r_owner;
  logic [N_DRV-1:0] r_en;
  logic [N_DRV-1:0] r_en_bar;
  logic [N_DRV-1:0] r_gnt;
  logic [W-1:0]     r_rx_data;
  logic [SRC_W-1:0] r_rx_src;
  logic             r_rx_valid;
  logic             r_busy;

  logic [N_DRV-1:0] w_arb_gnt;
  logic [SRC_W-1:0] w_arb_idx;
  logic             w_arb_any;

  tbuf_bus_rr_arb #(
    .N_DRV (N_DRV),
    .SRC_W (SRC_W)
  ) u_arb (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_arb_gnt),
    .o_idx  (w_arb_idx),
    .o_any  (w_arb_any)
  );

  // EN and EN_BAR are written together in every branch so the pair never skews.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_last     <= SRC_W'(N_DRV - 1);
      r_owner    <= '0;
      r_en       <= '0;
      r_en_bar   <= '1;
      r_gnt      <= '0;
      r_rx_data  <= '0;
      r_rx_src   <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_en     <= w_arb_gnt;
            r_en_bar <= ~w_arb_gnt;
            r_owner  <= w_arb_idx;
            r_cnt    <= C_SETTLE;
            r_busy   <= 1'b1;
            r_state  <= ST_DRIVE;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rx_data  <= bus.bus_in;
            r_rx_src   <= r_owner;
            r_rx_valid <= 1'b1;
            r_gnt      <= r_en;
            r_en       <= '0;
            r_en_bar   <= '1;
            r_last     <= r_owner;
            r_cnt      <= C_DEAD_M1;
            r_state    <= ST_DEAD;
          end
        end
        ST_DEAD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_en     <= '0;
          r_en_bar <= '1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.en       = r_en;
  assign bus.en_bar   = r_en_bar;
  assign bus.gnt      = r_gnt;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_src   = r_rx_src;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_tbuf_bus_ctrl.sv
// Scoreboard bench for tbuf_bus_ctrl: default instance (SETTLE=1, DEAD=1) and a SETTLE=3, DEAD=2 instance.
module tb_tbuf_bus_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  tbuf_bus_ctrl_if #(.N_DRV(N), .W(W)) bus_a ();
  tbuf_bus_ctrl_if #(.N_DRV(N), .W(W)) bus_b ();

  tbuf_bus_ctrl #(.N_DRV(N), .W(W), .SETTLE(1), .DEAD(1)) dut_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a.master)
  );

  tbuf_bus_ctrl #(.N_DRV(N), .W(W), .SETTLE(3), .DEAD(2)) dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b.master)
  );

  int checks;
  int errors;
  int cyc;
  int rise_cyc [2];
  int hi_run   [2];
  int lo_run   [2];
  int n_valid  [2];
  logic [N-1:0] prev_en [2];
  bit had_owner [2];
  exp_t q_a [$];
  exp_t q_b [$];
  int vc_a [$];
  int vc_b [$];

  logic       use_idx_a;
  logic [W-1:0] cval_a;
  logic [W-1:0] cval_b;

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int dead_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic exp_t mk(input int s, input logic [W-1:0] d);
    exp_t e;
    e.src  = SW'(s);
    e.data = d;
    return e;
  endfunction

  // Bus model: each driver puts 8'h10+index on the wire, or a constant value.
  always_comb begin
    if (use_idx_a && (bus_a.en != '0)) bus_a.bus_in = 8'h10 + W'(oh_idx(bus_a.en));
    else                               bus_a.bus_in = cval_a;
  end
  assign bus_b.bus_in = cval_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic mon_step(input int d, input logic rst, input logic [N-1:0] en,
                          input logic [N-1:0] en_bar, input logic [N-1:0] gnt,
                          input logic rxv, input logic [W-1:0] rxd,
                          input logic [SW-1:0] rxs, input logic busy);
    exp_t e;
    logic [N-1:0] inv;
    logic [N-1:0] g;
    if (rst) begin
      prev_en[d]   = '0;
      had_owner[d] = 1'b0;
      hi_run[d]    = 0;
      lo_run[d]    = 0;
    end else begin
      inv = ~en;
      chk("en_bar_pair", en_bar, inv);
      chk("en_onehot0", $onehot0(en), 1);
      if (en != '0) begin
        chk("busy_while_en", busy, 1);
        if (prev_en[d] != '0) chk("owner_no_direct_switch", en, prev_en[d]);
        if (prev_en[d] == '0) begin
          if (had_owner[d]) chk("dead_gap_min", lo_run[d] >= dead_of(d) + 1, 1);
          rise_cyc[d] = cyc;
          hi_run[d]   = 0;
        end
        hi_run[d]++;
      end else begin
        if (prev_en[d] != '0) begin
          chk("en_high_len", hi_run[d], settle_of(d) + 1);
          had_owner[d] = 1'b1;
          lo_run[d]    = 0;
        end
        lo_run[d]++;
      end
      if (rxv) begin
        n_valid[d]++;
        if (d == 0) vc_a.push_back(cyc);
        else        vc_b.push_back(cyc);
        if ((d == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
          chk("rx_unexpected", 1, 0);
        end else begin
          e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
          g = '0;
          g[e.src] = 1'b1;
          chk("rx_src", rxs, e.src);
          chk("rx_data", rxd, e.data);
          chk("gnt_onehot", gnt, g);
          chk("rx_latency", cyc - rise_cyc[d], settle_of(d) + 1);
        end
      end else begin
        chk("gnt_without_valid", gnt, 0);
      end
      prev_en[d] = en;
    end
  endtask

  // Monitor: samples both DUTs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    mon_step(0, rst_a, bus_a.en, bus_a.en_bar, bus_a.gnt, bus_a.rx_valid,
             bus_a.rx_data, bus_a.rx_src, bus_a.busy);
    mon_step(1, rst_b, bus_b.en, bus_b.en_bar, bus_b.gnt, bus_b.rx_valid,
             bus_b.rx_data, bus_b.rx_src, bus_b.busy);
  end

  task automatic check_rst(input string p, input logic [N-1:0] en, input logic [N-1:0] enb,
                           input logic [N-1:0] gnt, input logic rxv, input logic [W-1:0] rxd,
                           input logic [SW-1:0] rxs, input logic busy);
    chk({p, "_en"}, en, 0);
    chk({p, "_en_bar"}, enb, 32'hF);
    chk({p, "_gnt"}, gnt, 0);
    chk({p, "_rx_valid"}, rxv, 0);
    chk({p, "_rx_data"}, rxd, 0);
    chk({p, "_rx_src"}, rxs, 0);
    chk({p, "_busy"}, busy, 0);
  endtask

  task automatic wait_valids(input int d, input int n, input int budget);
    int k;
    k = 0;
    while ((n_valid[d] < n) && (k < budget)) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wait_valid_timeout", n_valid[d] >= n, 1);
  endtask

  task automatic wait_en_a(input logic [N-1:0] val, input int budget);
    int k;
    k = 0;
    while ((bus_a.en !== val) && (k < budget)) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wait_en_timeout", bus_a.en, val);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    bus_a.req = '0;
    repeat (2) @(negedge clk);
    #2 rst_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int d = 0; d < 2; d++) begin
      rise_cyc[d] = 0; hi_run[d] = 0; lo_run[d] = 0; n_valid[d] = 0;
      prev_en[d] = '0; had_owner[d] = 1'b0;
    end
    use_idx_a = 1'b0;
    cval_a    = 8'h00;
    cval_b    = 8'h00;
    bus_a.req = '0;
    bus_b.req = '0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_rst("rst_a", bus_a.en, bus_a.en_bar, bus_a.gnt, bus_a.rx_valid,
              bus_a.rx_data, bus_a.rx_src, bus_a.busy);
    check_rst("rst_b", bus_b.en, bus_b.en_bar, bus_b.gnt, bus_b.rx_valid,
              bus_b.rx_data, bus_b.rx_src, bus_b.busy);
    @(negedge clk);
    #2 rst_a = 1'b0; rst_b = 1'b0;

    // Single request from driver 0.
    cval_a = 8'hA5;
    q_a.push_back(mk(0, 8'hA5));
    base = n_valid[0];
    bus_a.req = 4'b0001;
    wait_valids(0, base + 1, 20);
    bus_a.req = '0;
    repeat (4) @(negedge clk);

    // All four requesting: fair rotation 0,1,2,3,0 at the 4-cycle minimum period.
    reset_a();
    use_idx_a = 1'b1;
    for (int i = 0; i < 5; i++) q_a.push_back(mk(i % 4, 8'h10 + W'(i % 4)));
    vc_a.delete();
    base = n_valid[0];
    bus_a.req = 4'b1111;
    wait_valids(0, base + 5, 60);
    bus_a.req = '0;
    if (vc_a.size() >= 5) for (int i = 1; i < 5; i++) chk("rr_period", vc_a[i] - vc_a[i-1], 4);
    repeat (6) @(negedge clk);
    use_idx_a = 1'b0;

    // Long settle / long dead time instance, driver 2 held for two transfers.
    cval_b = 8'h3C;
    q_b.push_back(mk(2, 8'h3C));
    q_b.push_back(mk(2, 8'h3C));
    vc_b.delete();
    base = n_valid[1];
    bus_b.req = 4'b0100;
    wait_valids(1, base + 2, 60);
    bus_b.req = '0;
    if (vc_b.size() >= 2) chk("b_period", vc_b[1] - vc_b[0], 7);

    // Requester drops one cycle into DRIVE: transfer still completes exactly once.
    reset_a();
    cval_a = 8'h5A;
    q_a.push_back(mk(1, 8'h5A));
    base = n_valid[0];
    bus_a.req = 4'b0010;
    wait_en_a(4'b0010, 20);
    @(posedge clk);
    #1 bus_a.req = '0;
    wait_valids(0, base + 1, 20);
    repeat (8) @(negedge clk);
    chk("dropped_req_single_valid", n_valid[0], base + 1);

    // Asynchronous reset in the middle of DRIVE.
    cval_a = 8'h77;
    bus_a.req = 4'b0010;
    wait_en_a(4'b0010, 20);
    rst_a = 1'b1;
    #1;
    check_rst("mid_rst", bus_a.en, bus_a.en_bar, bus_a.gnt, bus_a.rx_valid,
              bus_a.rx_data, bus_a.rx_src, bus_a.busy);
    @(negedge clk);
    cval_a = 8'hC3;
    q_a.push_back(mk(1, 8'hC3));
    base = n_valid[0];
    #2 rst_a = 1'b0;
    wait_valids(0, base + 1, 20);
    bus_a.req = '0;
    repeat (6) @(negedge clk);

    chk("scoreboard_a_drained", q_a.size(), 0);
    chk("scoreboard_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbuf_bus_ctrl.md
# tbuf_bus_ctrl

Controller and receiver for a shared tri-state bus built from `tbuf` cells. It grants exactly one of N_DRV drivers at a time by generating registered per-driver EN / EN_BAR pairs, with round-robin fairness and a mandatory break-before-make dead time. It waits a programmable settle time, then captures the resolved bus value and reports it with its source index. It sits at the receiving end of every tri-state bus segment in the standard-cell test designs.

## Interface
Parameters:
- N_DRV, 4: number of tbuf drivers on the bus (2..16)
- W, 8: bus width
- SETTLE, 1: extra cycles EN is held before sampling (≥0)
- DEAD, 1: cycles with all EN low between owners (≥1; 0 is illegal and asserts at elaboration)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous reset, active-high
- REQ  in  N_DRV  per-driver request level
- BUS_IN  in  W  resolved bus value (tbuf outputs tied together)
- EN  out  N_DRV  per-driver enable, at most one bit high, registered
- EN_BAR  out  N_DRV  always bitwise ~EN, registered (no skew between the pair)
- GNT  out  N_DRV  one-cycle pulse to the driver whose data was captured
- RX_DATA  out  W  last captured bus value
- RX_SRC  out  clog2(N_DRV)  index of the driver for RX_DATA
- RX_VALID  out  1  one-cycle pulse, RX_DATA/RX_SRC new
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DRIVE, DEAD.
- IDLE: if any REQ bit is high, the round-robin winner w is selected. Search starts at last_winner+1 and wraps modulo N_DRV. EN[w]←1, cnt←SETTLE, go to DRIVE. If no REQ, stay in IDLE.
- DRIVE: if cnt≠0, cnt−−. If cnt=0, then on this edge: RX_DATA←BUS_IN, RX_SRC←w, RX_VALID←1, GNT[w]←1, EN←0, last_winner←w, cnt←DEAD−1, go to DEAD.
- DEAD: all EN=0. Decrement cnt; at cnt=0 go to IDLE.
- REQ[w] deasserting during DRIVE does not abort the transfer. It completes and GNT[w] still pulses.
- REQ of other drivers during DRIVE/DEAD is ignored until the next IDLE evaluation.
- BUS_IN is captured as-is, including X/Z. No filtering.

Reset behaviour (async, effective immediately, any state):
- EN=0, EN_BAR=all ones, GNT=0, RX_VALID=0, RX_DATA=0, RX_SRC=0, BUSY=0.
- State IDLE, last_winner=N_DRV−1, so driver 0 wins first.
- On deassert, the first arbitration happens on the first CLK edge with REQ≠0.

## Timing
- Arbitration edge E0 (IDLE, REQ≠0): EN[w]/EN_BAR[w] change right after E0.
- Sample edge is E0+SETTLE+1. At that edge BUS_IN is captured, EN[w] falls, and RX_VALID/GNT go high for exactly one cycle.
- All EN stay low for DEAD full cycles. IDLE is entered at E0+SETTLE+1+DEAD.
- The next arbitration edge is E0+SETTLE+DEAD+2. That is the minimum transfer period, which is 4 cycles at the defaults.
- BUS_IN must be stable from SETTLE+1 cycles after EN rises. There is no combinational path from any input to any output.

## Structure
- Package tbuf_bus_pkg holds the state enum (IDLE, DRIVE, DEAD) and width helpers (clog2-based SRC_W, counter width from max(SETTLE, DEAD)).
- Sub-module tbuf_bus_rr_arb: combinational round-robin arbiter.
  - Inputs: REQ, last_winner.
  - Outputs: one-hot grant, index, any.
- The top holds the FSM, counter, EN/EN_BAR registers and capture registers.

## Test plan
- Reset then REQ=4'b0001, BUS_IN=8'hA5, defaults:
  - EN=0001 for 2 cycles.
  - RX_VALID pulses with RX_DATA=A5, RX_SRC=0, GNT=0001.
  - EN=0000 for 1 cycle.
- REQ=4'b1111 held, BUS_IN=8'h10+index of the enabled driver:
  - Grant order is 0,1,2,3,0.
  - RX_DATA sequence is 10,11,12,13,10.
  - Period is 4 cycles.
  - EN never has two bits set, and never goes from one owner to another without an all-zero cycle.
- SETTLE=3, DEAD=2, REQ=4'b0100:
  - EN[2] high for 4 cycles, then all EN low for 2 cycles.
  - RX_VALID occurs 4 edges after arbitration.
- REQ[1] dropped one cycle after EN[1] rises: the transfer completes, and GNT[1] and RX_VALID still pulse once.
- RST asserted mid-DRIVE with EN=0010:
  - EN=0000 and EN_BAR=1111 immediately, before the next edge.
  - RX_VALID=0 and RX_DATA=0.
  - After release with REQ=4'b0010, driver 1 wins.
- Across all tests, check every cycle that EN_BAR == ~EN and that EN is one-hot-or-zero.
